// File: rtl/exec_controller.sv
// Run/step/halt sequencer for the single-cycle core: one enable gates PC, register-file and DMEM updates.
// Buttons act three edges after they rise; a breakpoint drops the enable in the same cycle the PC matches.
module exec_controller (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        run_btn,
    input  logic        step_btn,
    input  logic        halt_btn,
    input  logic        bp_enable,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc_value,
    input  logic        clr_cnt,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [31:0] instr_count
);

    localparam logic [1:0] S_HALT  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_STEP  = 2'b10;
    localparam logic [1:0] S_BREAK = 2'b11;

    // Button vectors are ordered {halt, step, run}
    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_sync3;
    logic [1:0]  r_state;
    logic        r_skip_bp;
    logic [31:0] r_instr_count;

    logic [2:0]  w_edge;
    logic        w_halt_p;
    logic        w_step_p;
    logic        w_run_p;
    logic        w_bp_hit;
    logic        w_cpu_en;
    logic [1:0]  w_state_nxt;
    logic        w_skip_nxt;

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_sync3 <= 3'b000;
        end else begin
            r_sync1 <= {halt_btn, step_btn, run_btn};
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge   = r_sync2 & ~r_sync3;
    assign w_halt_p = w_edge[2];
    assign w_step_p = w_edge[1] & ~w_edge[2];
    assign w_run_p  = w_edge[0] & ~w_edge[1] & ~w_edge[2];
    assign w_bp_hit = bp_enable & (pc_value == bp_addr) & ~r_skip_bp;

    always_comb begin
        w_cpu_en    = 1'b0;
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip_bp;
        case (r_state)
            S_HALT: begin
                if (w_step_p)     w_state_nxt = S_STEP;
                else if (w_run_p) w_state_nxt = S_RUN;
            end
            S_STEP: begin
                w_cpu_en    = 1'b1;
                w_state_nxt = S_HALT;
            end
            S_RUN: begin
                w_cpu_en = ~w_bp_hit & ~w_halt_p;
                if (w_halt_p)      w_state_nxt = S_HALT;
                else if (w_bp_hit) w_state_nxt = S_BREAK;
                if (w_cpu_en)      w_skip_nxt  = 1'b0;
            end
            default: begin
                if (w_halt_p) begin
                    w_state_nxt = S_HALT;
                end else if (w_step_p) begin
                    w_state_nxt = S_STEP;
                end else if (w_run_p) begin
                    w_state_nxt = S_RUN;
                    w_skip_nxt  = 1'b1;
                end
            end
        endcase
        // Any return to HALT forgets a pending breakpoint skip
        if (w_state_nxt == S_HALT) w_skip_nxt = 1'b0;
    end

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            r_state       <= S_HALT;
            r_skip_bp     <= 1'b0;
            r_instr_count <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_skip_bp <= w_skip_nxt;
            if (clr_cnt)       r_instr_count <= 32'd0;
            else if (w_cpu_en) r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign cpu_en      = w_cpu_en;
    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_exec_controller.sv
// Bench for exec_controller: a small PC model feeds pc_value; expected state transitions go through a scoreboard queue.
module tb_exec_controller;

    typedef struct packed {
        logic [1:0]  st;
        logic        en;
        logic [31:0] cnt;
    } exp_t;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset = 1'b1;
    logic        run_btn = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt_btn = 1'b0;
    logic        bp_enable = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        pc_load = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        cpu_en;
    logic [1:0]  state;
    logic [31:0] instr_count;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [1:0] prev_state = 2'b00;

    exec_controller dut (
        .SYS_clk    (SYS_clk),
        .SYS_reset  (SYS_reset),
        .run_btn    (run_btn),
        .step_btn   (step_btn),
        .halt_btn   (halt_btn),
        .bp_enable  (bp_enable),
        .bp_addr    (bp_addr),
        .pc_value   (pc),
        .clr_cnt    (clr_cnt),
        .cpu_en     (cpu_en),
        .state      (state),
        .instr_count(instr_count)
    );

    always #5 SYS_clk = ~SYS_clk;

    // Minimal processor PC: advances by 4 on each enabled edge
    always @(posedge SYS_clk) begin
        if (pc_load)     pc <= 32'd0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic en, input logic [31:0] cnt);
        exp_t e;
        e.st  = st;
        e.en  = en;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic wait_state(input logic [1:0] s, input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge SYS_clk);
            if (state == s) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout, state %b expected %b", name, state, s);
    endtask

    // Monitor: every observed state change is matched against the next expected record
    always @(negedge SYS_clk) begin
        if (SYS_reset) begin
            prev_state = 2'b00;
        end else if (state !== prev_state) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_transition: got state %b from %b expected none", state, prev_state);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_state", {30'd0, state}, {30'd0, e.st});
                chk("sb_cpu_en", {31'd0, cpu_en}, {31'd0, e.en});
                chk("sb_count", instr_count, e.cnt);
            end
            prev_state = state;
        end
    end

    task automatic restart_pc_and_count();
        @(negedge SYS_clk);
        pc_load = 1'b1;
        clr_cnt = 1'b1;
        @(negedge SYS_clk);
        pc_load = 1'b0;
        clr_cnt = 1'b0;
        chk("clear_count", instr_count, 32'd0);
        chk("clear_pc", pc, 32'd0);
    endtask

    initial begin
        // Reset
        repeat (3) begin
            @(negedge SYS_clk);
            chk("reset_state", {30'd0, state}, 32'd0);
            chk("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
        end
        chk("reset_count", instr_count, 32'd0);
        SYS_reset = 1'b0;
        repeat (2) @(negedge SYS_clk);

        // Single step from HALT
        push(2'b10, 1'b1, 32'd0);
        push(2'b00, 1'b0, 32'd1);
        step_btn = 1'b1;
        wait_state(2'b10, "step_enter");
        wait_state(2'b00, "step_exit");
        repeat (2) @(negedge SYS_clk);
        step_btn = 1'b0;
        chk("step_count", instr_count, 32'd1);

        // Free run, halt 20 cycles after entry
        restart_pc_and_count();
        push(2'b01, 1'b1, 32'd0);
        push(2'b00, 1'b0, 32'd22);
        run_btn = 1'b1;
        wait_state(2'b01, "run_enter");
        run_btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge SYS_clk);
            chk("run_cpu_en", {31'd0, cpu_en}, 32'd1);
        end
        halt_btn = 1'b1;
        wait_state(2'b00, "run_halt");
        halt_btn = 1'b0;
        chk("run_halt_pc", pc, 32'h58);

        // Breakpoint at 0x10, then resume without re-breaking
        bp_enable = 1'b1;
        bp_addr   = 32'h10;
        restart_pc_and_count();
        push(2'b01, 1'b1, 32'd0);
        push(2'b11, 1'b0, 32'd4);
        run_btn = 1'b1;
        wait_state(2'b01, "bp_run");
        run_btn = 1'b0;
        wait_state(2'b11, "bp_break");
        chk("bp_pc", pc, 32'h10);
        chk("bp_cpu_en", {31'd0, cpu_en}, 32'd0);
        push(2'b01, 1'b1, 32'd4);
        push(2'b00, 1'b0, 32'd9);
        run_btn = 1'b1;
        wait_state(2'b01, "resume_run");
        run_btn = 1'b0;
        repeat (3) begin
            @(negedge SYS_clk);
            chk("resume_state", {30'd0, state}, 32'd1);
            chk("resume_cpu_en", {31'd0, cpu_en}, 32'd1);
        end
        halt_btn = 1'b1;
        wait_state(2'b00, "resume_halt");
        halt_btn = 1'b0;
        chk("resume_pc", pc, 32'h24);

        // Step out of BREAK executes the breakpoint instruction
        restart_pc_and_count();
        push(2'b01, 1'b1, 32'd0);
        push(2'b11, 1'b0, 32'd4);
        run_btn = 1'b1;
        wait_state(2'b01, "bp2_run");
        run_btn = 1'b0;
        wait_state(2'b11, "bp2_break");
        push(2'b10, 1'b1, 32'd4);
        push(2'b00, 1'b0, 32'd5);
        step_btn = 1'b1;
        wait_state(2'b10, "bstep_enter");
        wait_state(2'b00, "bstep_exit");
        step_btn = 1'b0;
        chk("bstep_pc", pc, 32'h14);
        chk("bstep_count", instr_count, 32'd5);

        // Run and step together in HALT: step wins, one instruction
        repeat (2) @(negedge SYS_clk);
        push(2'b10, 1'b1, 32'd5);
        push(2'b00, 1'b0, 32'd6);
        run_btn  = 1'b1;
        step_btn = 1'b1;
        wait_state(2'b10, "simul_step");
        wait_state(2'b00, "simul_halt");
        repeat (6) @(negedge SYS_clk);
        chk("simul_state", {30'd0, state}, 32'd0);
        chk("simul_count", instr_count, 32'd6);
        run_btn  = 1'b0;
        step_btn = 1'b0;

        // Halt and run together in BREAK: halt wins
        restart_pc_and_count();
        push(2'b01, 1'b1, 32'd0);
        push(2'b11, 1'b0, 32'd4);
        run_btn = 1'b1;
        wait_state(2'b01, "bp3_run");
        run_btn = 1'b0;
        wait_state(2'b11, "bp3_break");
        push(2'b00, 1'b0, 32'd4);
        halt_btn = 1'b1;
        run_btn  = 1'b1;
        wait_state(2'b00, "bhalt");
        repeat (4) @(negedge SYS_clk);
        chk("bhalt_state", {30'd0, state}, 32'd0);
        chk("bhalt_pc", pc, 32'h10);
        chk("bhalt_count", instr_count, 32'd4);
        halt_btn  = 1'b0;
        run_btn   = 1'b0;
        bp_enable = 1'b0;

        // Counter wrap
        @(negedge SYS_clk);
        force dut.r_instr_count = 32'hFFFF_FFFF;
        @(negedge SYS_clk);
        release dut.r_instr_count;
        @(negedge SYS_clk);
        chk("wrap_preload", instr_count, 32'hFFFF_FFFF);
        push(2'b10, 1'b1, 32'hFFFF_FFFF);
        push(2'b00, 1'b0, 32'd0);
        step_btn = 1'b1;
        wait_state(2'b10, "wrap_step");
        wait_state(2'b00, "wrap_halt");
        step_btn = 1'b0;
        chk("wrap_count", instr_count, 32'd0);

        // Clear beats increment while running
        push(2'b01, 1'b1, 32'd0);
        push(2'b00, 1'b0, 32'd2);
        run_btn = 1'b1;
        wait_state(2'b01, "clr_run");
        run_btn = 1'b0;
        repeat (2) @(negedge SYS_clk);
        chk("clr_pre", instr_count, 32'd2);
        clr_cnt = 1'b1;
        @(negedge SYS_clk);
        clr_cnt = 1'b0;
        chk("clr_count", instr_count, 32'd0);
        chk("clr_cpu_en", {31'd0, cpu_en}, 32'd1);
        halt_btn = 1'b1;
        wait_state(2'b00, "clr_halt");
        halt_btn = 1'b0;

        repeat (3) @(negedge SYS_clk);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
